// File: rtl/ringpll_ctrl.sv
// ringpll_ctrl: ring PLL power-up, lock supervision, shutdown and error sequencer
module ringpll_ctrl #(
  parameter int LdoSettleCycles   = 64,
  parameter int LockStableCycles  = 16,
  parameter int LockTimeoutCycles = 4096
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_i,
  input  logic [9:0]  ratio_i,
  input  logic [23:0] fraction_i,
  input  logic        lock_i,
  output logic        ldo_enable_o,
  output logic        pllen_o,
  output logic [9:0]  ratio_o,
  output logic [23:0] fraction_o,
  output logic        bypass_o,
  output logic        ready_o,
  output logic        err_o
);
  localparam int MaxAb  = LdoSettleCycles > LockStableCycles ? LdoSettleCycles : LockStableCycles;
  localparam int MaxCyc = MaxAb > LockTimeoutCycles ? MaxAb : LockTimeoutCycles;
  localparam int CW     = $clog2(MaxCyc + 1);
  localparam logic [CW-1:0] LdoLast     = CW'(LdoSettleCycles - 1);
  localparam logic [CW-1:0] StableLast  = CW'(LockStableCycles - 1);
  localparam logic [CW-1:0] TimeoutLast = CW'(LockTimeoutCycles - 1);
  localparam logic [2:0] OFF    = 3'd0;
  localparam logic [2:0] LDO_ON = 3'd1;
  localparam logic [2:0] PLL_EN = 3'd2;
  localparam logic [2:0] LOCKED = 3'd3;
  localparam logic [2:0] SHUTDN = 3'd4;
  localparam logic [2:0] ERROR  = 3'd5;
  logic [1:0]    sync;
  logic          lock_s;
  logic [2:0]    state, nxt;
  logic [CW-1:0] cnt, stable;
  logic          entry, latch;
  assign lock_s = sync[1];
  assign entry  = nxt != state;
  assign latch  = state == OFF && nxt == LDO_ON;
  // two-flop synchronizer for the asynchronous lock indication
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) sync <= 2'b00;
    else sync <= {sync[0], lock_i};
  end
  // next state: shutdown request beats lock loss/timeout, stable lock beats timeout
  always_comb begin
    nxt = state;
    case (state)
      OFF:     nxt = !req_i ? OFF : (ratio_i != '0 ? LDO_ON : ERROR);
      LDO_ON:  nxt = !req_i ? SHUTDN : (cnt >= LdoLast ? PLL_EN : LDO_ON);
      PLL_EN:  nxt = !req_i ? SHUTDN : (lock_s && stable >= StableLast) ? LOCKED :
                     (cnt >= TimeoutLast ? ERROR : PLL_EN);
      LOCKED:  nxt = !req_i ? SHUTDN : (lock_s ? LOCKED : ERROR);
      SHUTDN:  nxt = OFF;
      ERROR:   nxt = req_i ? ERROR : OFF;
      default: nxt = OFF;
    endcase
  end
  // state and saturating counters, cleared whenever a state is entered
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state  <= OFF;
      cnt    <= '0;
      stable <= '0;
    end else begin
      state  <= nxt;
      cnt    <= entry ? '0 : (cnt == '1 ? cnt : cnt + 1'b1);
      stable <= (entry || state != PLL_EN || !lock_s) ? '0 : (stable == '1 ? stable : stable + 1'b1);
    end
  end
  // outputs registered from the next state so they line up with the state register
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      ldo_enable_o <= 1'b0;
      pllen_o      <= 1'b0;
      bypass_o     <= 1'b1;
      ready_o      <= 1'b0;
      err_o        <= 1'b0;
      ratio_o      <= '0;
      fraction_o   <= '0;
    end else begin
      ldo_enable_o <= nxt == LDO_ON || nxt == PLL_EN || nxt == LOCKED || nxt == SHUTDN;
      pllen_o      <= nxt == PLL_EN || nxt == LOCKED;
      bypass_o     <= nxt != LOCKED;
      ready_o      <= nxt == LOCKED;
      err_o        <= nxt == ERROR ? 1'b1 : (latch ? 1'b0 : err_o);
      ratio_o      <= latch ? ratio_i : ratio_o;
      fraction_o   <= latch ? fraction_i : fraction_o;
    end
  end
endmodule

// File: tb/tb_ringpll_ctrl.sv
// tb_ringpll_ctrl: directed and randomized checks of ringpll_ctrl against a behavioural model
module tb_ringpll_ctrl;
  localparam int LDO = 4, STB = 3, TMO = 20;
  logic        clk_i = 1'b0, rst_ni = 1'b0, req_i = 1'b0, lock_i = 1'b0;
  logic [9:0]  ratio_i = '0;
  logic [23:0] fraction_i = '0;
  logic        ldo_enable_o, pllen_o, bypass_o, ready_o, err_o;
  logic [9:0]  ratio_o;
  logic [23:0] fraction_o;
  int checks = 0, failures = 0;

  ringpll_ctrl #(.LdoSettleCycles(LDO), .LockStableCycles(STB), .LockTimeoutCycles(TMO)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .req_i(req_i), .ratio_i(ratio_i), .fraction_i(fraction_i),
    .lock_i(lock_i), .ldo_enable_o(ldo_enable_o), .pllen_o(pllen_o), .ratio_o(ratio_o),
    .fraction_o(fraction_o), .bypass_o(bypass_o), .ready_o(ready_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum int {M_OFF, M_LDO, M_PLL, M_LOCKED, M_SHUT, M_ERR} mph_t;
  mph_t        ph;
  int          age, streak;
  bit          e_err;
  logic [9:0]  e_ratio;
  logic [23:0] e_frac;
  bit          lq[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    ph = M_OFF; age = 0; streak = 0; e_err = 0; e_ratio = '0; e_frac = '0;
    lq.delete(); lq.push_back(1'b0); lq.push_back(1'b0);
  endtask

  task automatic check_all(input string tag);
    chk({tag, ":ldo"},    ldo_enable_o, ph == M_LDO || ph == M_PLL || ph == M_LOCKED || ph == M_SHUT);
    chk({tag, ":pllen"},  pllen_o,      ph == M_PLL || ph == M_LOCKED);
    chk({tag, ":bypass"}, bypass_o,     ph != M_LOCKED);
    chk({tag, ":ready"},  ready_o,      ph == M_LOCKED);
    chk({tag, ":err"},    err_o,        e_err);
    chk({tag, ":ratio"},  ratio_o,      e_ratio);
    chk({tag, ":frac"},   fraction_o,   e_frac);
  endtask

  // one clock: lock seen by the controller is lock_i from two edges back
  task automatic step(input string tag);
    bit ls;
    mph_t nx;
    int a, run;
    ls = lq[0];
    lq.push_back(lock_i);
    void'(lq.pop_front());
    streak = ls ? streak + 1 : 0;
    a = age + 1;
    run = streak < a ? streak : a;
    nx = ph;
    case (ph)
      M_OFF:    if (req_i) nx = (ratio_i != 0) ? M_LDO : M_ERR;
      M_LDO:    if (!req_i) nx = M_SHUT; else if (a >= LDO) nx = M_PLL;
      M_PLL:    if (!req_i) nx = M_SHUT; else if (ls && run >= STB) nx = M_LOCKED; else if (a >= TMO) nx = M_ERR;
      M_LOCKED: if (!req_i) nx = M_SHUT; else if (!ls) nx = M_ERR;
      M_SHUT:   nx = M_OFF;
      M_ERR:    if (!req_i) nx = M_OFF;
      default:  nx = M_OFF;
    endcase
    if (ph == M_OFF && nx == M_LDO) begin
      e_err = 0; e_ratio = ratio_i; e_frac = fraction_i;
    end
    if (nx == M_ERR) e_err = 1;
    age = (nx == ph) ? a : 0;
    ph = nx;
    @(posedge clk_i);
    #1;
    check_all(tag);
  endtask

  task automatic steps(input string tag, input int n);
    for (int i = 0; i < n; i++) step(tag);
  endtask

  task automatic go_off();
    req_i = 0; lock_i = 0;
    steps("go_off", 3);
  endtask

  task automatic to_locked(input string tag, output int n);
    go_off();
    req_i = 1; ratio_i = 10'($urandom_range(1, 1023)); fraction_i = 24'($urandom); lock_i = 1;
    n = 0;
    while (!ready_o && n < 40) begin step(tag); n++; end
    chk({tag, ":reached_locked"}, ready_o, 1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    model_reset();
    @(posedge clk_i); @(posedge clk_i); #1;
    check_all("reset");
    rst_ni = 1;
    steps("idle", 2);

    // bring-up with mid-sequence config changes ignored
    req_i = 1; ratio_i = 10'd40; fraction_i = 24'($urandom);
    step("bringup_c1");
    chk("ldo_at_cycle1", ldo_enable_o, 1'b1);
    n = 1;
    while (!pllen_o && n < 20) begin ratio_i = 10'($urandom); fraction_i = 24'($urandom); step("bringup"); n++; end
    chk("pllen_cycle", n, 5);
    steps("pre_lock", 5);
    lock_i = 1;
    n = 0;
    while (!ready_o && n < 20) begin step("lock_wait"); n++; end
    chk("ready_latency", n, 5);
    chk("ratio_40", ratio_o, 10'd40);
    chk("bypass_locked", bypass_o, 1'b0);
    req_i = 0;
    step("shutdn");
    chk("shutdn_ldo", ldo_enable_o, 1'b1);
    chk("shutdn_pllen", pllen_o, 1'b0);
    step("shutdn_off");
    lock_i = 0;

    // lock glitch restarts the stable count
    req_i = 1; ratio_i = 10'($urandom_range(1, 1023));
    n = 0;
    while (!pllen_o && n < 20) begin step("glitch_up"); n++; end
    lock_i = 1; steps("glitch_h", 2);
    lock_i = 0; step("glitch_l");
    lock_i = 1;
    n = 0;
    while (!ready_o && n < 20) begin step("glitch_wait"); n++; end
    chk("glitch_ready_latency", n, 5);
    chk("glitch_err", err_o, 1'b0);

    // lock loss while locked, then recover through OFF
    lock_i = 0; step("loss_drop");
    lock_i = 1; steps("loss", 3);
    chk("loss_err", err_o, 1'b1);
    chk("loss_ready", ready_o, 1'b0);
    steps("err_hold", 2);
    req_i = 0; step("err_off");
    req_i = 1; ratio_i = 10'($urandom_range(1, 1023)); step("err_clear");
    chk("err_cleared", err_o, 1'b0);

    // lock loss coincident with shutdown request
    to_locked("conc", n);
    lock_i = 0; step("conc_drop");
    lock_i = 1; step("conc_1");
    req_i = 0; step("conc_2");
    chk("conc_shutdn_ldo", ldo_enable_o, 1'b1);
    chk("conc_no_err", err_o, 1'b0);
    step("conc_off");

    // timeout with no lock
    lock_i = 0; req_i = 1; ratio_i = 10'($urandom_range(1, 1023));
    n = 0;
    while (!pllen_o && n < 20) begin step("tmo_up"); n++; end
    n = 0;
    while (!err_o && n < 40) begin step("tmo_wait"); n++; end
    chk("timeout_cycles", n, TMO);
    chk("timeout_pllen", pllen_o, 1'b0);
    req_i = 0; step("tmo_off");
    chk("tmo_err_sticky", err_o, 1'b1);

    // stable lock reached on the timeout cycle wins
    req_i = 1; step("tie_latch");
    chk("tie_err_clear", err_o, 1'b0);
    n = 0;
    while (!pllen_o && n < 20) begin step("tie_up"); n++; end
    steps("tie_wait", 15);
    lock_i = 1; steps("tie_lock", 5);
    chk("tie_locked", ready_o, 1'b1);
    chk("tie_no_err", err_o, 1'b0);

    // zero ratio is a configuration error
    go_off();
    req_i = 1; ratio_i = '0;
    steps("badcfg", 4);
    chk("badcfg_ldo", ldo_enable_o, 1'b0);
    chk("badcfg_err", err_o, 1'b1);
    req_i = 0; step("badcfg_off");

    // randomized soak
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 15) == 0) req_i = ~req_i;
      if ($urandom_range(0, 7) == 0) lock_i = ~lock_i;
      ratio_i = ($urandom_range(0, 7) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
      fraction_i = 24'($urandom);
      step("soak");
    end

    // asynchronous reset while locked
    to_locked("rst", n);
    #3 rst_ni = 0;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk_i); #1;
    check_all("reset_held");
    rst_ni = 1; req_i = 0;
    steps("post_reset", 2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
